// File: rtl/dp_dmi_ctrl_pkg.sv
// Shared types for the DMI controller: register addresses, op/status
// encodings, FSM states and the implemented-address decode.
package dp_dmr_types;

    localparam int unsigned OpW = 2;

    // Debug-module register addresses, held 32 bits wide so the decode
    // works for any ADDR_W up to 32.
    localparam logic [31:0] AddrData0        = 32'h04;
    localparam logic [31:0] AddrData1        = 32'h05;
    localparam logic [31:0] AddrDmcontrol    = 32'h10;
    localparam logic [31:0] AddrDmstatus     = 32'h11;
    localparam logic [31:0] AddrHartinfo     = 32'h12;
    localparam logic [31:0] AddrAbstractcs   = 32'h16;
    localparam logic [31:0] AddrCommand      = 32'h17;
    localparam logic [31:0] AddrAbstractauto = 32'h18;
    localparam logic [31:0] AddrProgbuf0     = 32'h20;
    localparam logic [31:0] AddrHaltsum0     = 32'h40;

    typedef enum logic [OpW-1:0] {
        OpNop   = 2'd0,
        OpRead  = 2'd1,
        OpWrite = 2'd2,
        OpRsvd  = 2'd3
    } dmi_op_e;

    typedef enum logic [OpW-1:0] {
        StatSuccess = 2'd0,
        StatFailed  = 2'd2
    } dmi_status_e;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    function automatic logic addr_implemented(input logic [31:0] addr);
        case (addr)
            AddrData0, AddrData1, AddrDmcontrol, AddrDmstatus, AddrHartinfo,
            AddrAbstractcs, AddrCommand, AddrAbstractauto, AddrProgbuf0,
            AddrHaltsum0: return 1'b1;
            default:      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dp_dmi_ctrl_if.sv
// DTM-side request/response handshake bundle.
interface dp_dmi_ctrl_if
    import dp_dmr_types::*;
#(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [OpW-1:0]    req_op;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [OpW-1:0]    resp_op;

    // DTM side
    modport master (
        output req_valid, req_addr, req_data, req_op, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_op
    );

    // Controller side
    modport slave (
        input  req_valid, req_addr, req_data, req_op, resp_ready,
        output req_ready, resp_valid, resp_data, resp_op
    );
endinterface

// File: rtl/dp_dmi_ctrl.sv
// DMI controller: accepts one DTM request at a time, performs a single-cycle
// register-file access when the request is legal, and returns a buffered
// response. Illegal requests set a sticky error that blocks later accesses
// until dmi_reset.
module dp_dmi_ctrl
    import dp_dmr_types::*;
#(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    dp_dmi_ctrl_if.slave      dtm,
    input  logic              dmi_reset,
    output logic [ADDR_W-1:0] dmi_address,
    output logic [DATA_W-1:0] dmi_wdata,
    output logic [OpW-1:0]    dmi_op,
    input  logic [DATA_W-1:0] dmi_rdata,
    output logic              sticky_err
);

    state_e state;
    logic   req_nop;
    logic   req_ok;
    logic   req_err;

    assign dtm.req_ready = (state == StIdle);

    // Classify the incoming request: legal access, nop, or error-setting.
    always_comb begin
        logic impl;
        impl    = addr_implemented(32'(dtm.req_addr));
        req_nop = (dtm.req_op == OpNop);
        req_err = (dtm.req_op == OpRsvd) || (!req_nop && !impl);
        req_ok  = ((dtm.req_op == OpRead) || (dtm.req_op == OpWrite)) && impl && !sticky_err;
    end

    // Controller FSM with registered dmi and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= StIdle;
            dtm.resp_valid <= 1'b0;
            dtm.resp_data  <= '0;
            dtm.resp_op    <= StatSuccess;
            dmi_op         <= OpNop;
            dmi_address    <= '0;
            dmi_wdata      <= '0;
            sticky_err     <= 1'b0;
        end else begin
            // A clear is overridden by an error set later in this block.
            if (dmi_reset) begin
                sticky_err <= 1'b0;
            end
            case (state)
                StIdle: begin
                    if (dtm.req_valid) begin
                        if (req_ok) begin
                            dmi_address <= dtm.req_addr;
                            dmi_wdata   <= dtm.req_data;
                            dmi_op      <= dtm.req_op;
                            state       <= StAccess;
                        end else begin
                            dtm.resp_valid <= 1'b1;
                            dtm.resp_data  <= '0;
                            dtm.resp_op    <= req_nop ? StatSuccess : StatFailed;
                            state          <= StResp;
                            if (req_err) begin
                                sticky_err <= 1'b1;
                            end
                        end
                    end
                end
                StAccess: begin
                    dtm.resp_data  <= (dmi_op == OpRead) ? dmi_rdata : '0;
                    dtm.resp_op    <= StatSuccess;
                    dtm.resp_valid <= 1'b1;
                    dmi_op         <= OpNop;
                    state          <= StResp;
                end
                StResp: begin
                    if (dtm.resp_ready) begin
                        dtm.resp_valid <= 1'b0;
                        state          <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dp_dmi_ctrl.sv
// Self-checking bench for dp_dmi_ctrl: directed scenarios followed by random
// transactions, each compared against a transaction-level model.
module tb_dp_dmi_ctrl;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              dmi_reset = 1'b0;
    logic [ADDR_W-1:0] dmi_address;
    logic [DATA_W-1:0] dmi_wdata;
    logic [1:0]        dmi_op;
    logic [DATA_W-1:0] dmi_rdata = '0;
    logic              sticky_err;

    dp_dmi_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dtm ();

    dp_dmi_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .dtm         (dtm),
        .dmi_reset   (dmi_reset),
        .dmi_address (dmi_address),
        .dmi_wdata   (dmi_wdata),
        .dmi_op      (dmi_op),
        .dmi_rdata   (dmi_rdata),
        .sticky_err  (sticky_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit model_sticky = 1'b0;

    logic [6:0] impl_list [10] = '{7'h04, 7'h05, 7'h10, 7'h11, 7'h12,
                                   7'h16, 7'h17, 7'h18, 7'h20, 7'h40};

    function automatic bit is_impl(input logic [6:0] a);
        foreach (impl_list[i]) if (impl_list[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_ctrl"},
                 64'({dtm.req_ready, dtm.resp_valid, dtm.resp_op, dmi_op, sticky_err, dmi_address}),
                 64'({1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 7'd0}));
        check_eq({tag, "_data"}, 64'({dtm.resp_data, dmi_wdata}), 64'd0);
    endtask

    task automatic pulse_dmi_reset();
        @(negedge clk);
        dmi_reset = 1'b1;
        @(negedge clk);
        dmi_reset = 1'b0;
        model_sticky = 1'b0;
    endtask

    // mode 0: no dmi_reset; 1: dmi_reset in the accept cycle; 2: dmi_reset while in flight
    task automatic run_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int hold, input int mode);
        bit          impl, nop, err_set, ok, got_resp;
        logic [1:0]  exp_status;
        logic [31:0] exp_data;
        int          exp_lat, cycles, dmi_cnt;
        logic [6:0]  seen_addr;
        logic [31:0] seen_wdata;
        logic [1:0]  seen_op;

        impl       = is_impl(addr);
        nop        = (op == 2'd0);
        err_set    = (op == 2'd3) || (!nop && !impl);
        ok         = (op == 2'd1 || op == 2'd2) && impl && !model_sticky;
        exp_status = (nop || ok) ? 2'd0 : 2'd2;
        exp_data   = (ok && op == 2'd1) ? rd : 32'd0;
        exp_lat    = ok ? 2 : 1;

        @(negedge clk);
        check_eq("idle_ready", 64'(dtm.req_ready), 64'd1);
        dtm.req_valid = 1'b1;
        dtm.req_op    = op;
        dtm.req_addr  = addr;
        dtm.req_data  = wd;
        dmi_rdata     = rd;
        dmi_reset     = (mode == 1);
        @(posedge clk);
        #1;
        dtm.req_valid = 1'b0;
        dtm.req_addr  = 7'($urandom);
        dtm.req_data  = $urandom;
        dtm.req_op    = 2'($urandom);
        dmi_reset     = 1'b0;
        if (err_set) model_sticky = 1'b1;
        else if (mode == 1) model_sticky = 1'b0;

        cycles = 0; dmi_cnt = 0; got_resp = 1'b0;
        seen_addr = '0; seen_wdata = '0; seen_op = '0;
        while (cycles < 6 && !got_resp) begin
            @(negedge clk);
            cycles++;
            if (dmi_op != 2'd0) begin
                dmi_cnt++;
                seen_addr = dmi_address; seen_wdata = dmi_wdata; seen_op = dmi_op;
            end
            if (dtm.resp_valid) got_resp = 1'b1;
        end
        if (!got_resp) begin
            check_eq("resp_timeout", 64'd0, 64'd1);
            return;
        end
        check_eq("latency", 64'(cycles), 64'(exp_lat));
        check_eq("dmi_access_count", 64'(dmi_cnt), 64'(ok ? 1 : 0));
        if (ok) begin
            check_eq("dmi_access", 64'({seen_op, seen_addr, seen_wdata}), 64'({op, addr, wd}));
        end
        check_eq("resp", 64'({dtm.resp_op, dtm.resp_data}), 64'({exp_status, exp_data}));
        check_eq("sticky_at_resp", 64'({sticky_err, dtm.req_ready}), 64'({model_sticky, 1'b0}));

        if (mode == 2) begin
            dmi_reset = 1'b1;
            model_sticky = 1'b0;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            dmi_reset = 1'b0;
            check_eq("resp_hold",
                     64'({dtm.resp_valid, dtm.req_ready, dtm.resp_op, dtm.resp_data, dmi_op}),
                     64'({1'b1, 1'b0, exp_status, exp_data, 2'd0}));
        end
        dtm.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        dtm.resp_ready = 1'b0;
        dmi_reset      = 1'b0;
        @(negedge clk);
        check_eq("after_handshake", 64'({dtm.resp_valid, dtm.req_ready, sticky_err}),
                 64'({1'b0, 1'b1, model_sticky}));
    endtask

    task automatic reset_during_write();
        bit seen_resp;
        @(negedge clk);
        dtm.req_valid = 1'b1;
        dtm.req_op    = 2'd2;
        dtm.req_addr  = 7'h10;
        dtm.req_data  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        dtm.req_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_pre_access", 64'(dmi_op), 64'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_sticky = 1'b0;
        @(negedge clk);
        check_reset_values("rst_in_access");
        seen_resp = 1'b0;
        dtm.resp_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (dtm.resp_valid || dmi_op != 2'd0) seen_resp = 1'b1;
        end
        dtm.resp_ready = 1'b0;
        check_eq("rst_no_resp", 64'(seen_resp), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] op;
        logic [6:0] addr;
        int         mode;

        dtm.req_valid  = 1'b0;
        dtm.req_addr   = '0;
        dtm.req_data   = '0;
        dtm.req_op     = '0;
        dtm.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("reset");

        run_txn(2'd1, 7'h11, 32'h0, 32'h0000_0C82, 0, 0);
        run_txn(2'd2, 7'h10, 32'h8000_0001, $urandom, 0, 0);
        run_txn(2'd1, 7'h7F, 32'h0, $urandom, 1, 0);
        run_txn(2'd1, 7'h04, 32'h0, $urandom, 0, 0);
        pulse_dmi_reset();
        run_txn(2'd1, 7'h04, 32'h0, 32'h1234_5678, 0, 0);
        run_txn(2'd1, 7'h12, 32'h0, 32'hCAFE_F00D, 5, 0);
        run_txn(2'd3, 7'h10, 32'h0, $urandom, 0, 0);
        run_txn(2'd0, 7'h11, 32'h5, $urandom, 1, 0);
        run_txn(2'd0, 7'h7F, 32'h5, $urandom, 2, 2);
        run_txn(2'd2, 7'h17, 32'h0000_0001, $urandom, 2, 2);
        run_txn(2'd3, 7'h04, 32'h0, $urandom, 0, 1);
        run_txn(2'd1, 7'h05, 32'h0, $urandom, 0, 1);
        reset_during_write();
        run_txn(2'd1, 7'h40, 32'h0, 32'h0000_0001, 0, 0);

        for (int t = 0; t < 200; t++) begin
            case ($urandom_range(0, 9))
                0:          op = 2'd0;
                1, 2, 3, 4: op = 2'd1;
                9:          op = 2'd3;
                default:    op = 2'd2;
            endcase
            addr = ($urandom_range(0, 9) < 7) ? impl_list[$urandom_range(0, 9)] : 7'($urandom);
            case ($urandom_range(0, 9))
                0:       mode = 1;
                1:       mode = 2;
                default: mode = 0;
            endcase
            run_txn(op, addr, $urandom, $urandom, $urandom_range(0, 3), mode);
            if (model_sticky && $urandom_range(0, 3) == 0) pulse_dmi_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
